// File: rtl/bio_gpio_infilt.sv
// Pad input conditioning for the BIO gpio_in bus: synchroniser, per-pin glitch filter, edge events.
// Optional macro BIO_GPIO_EDGE_EN enables edge detection, pending flags and evt_irq.
module bio_gpio_infilt #(
    parameter int NPIN = 32,
    parameter int SYNC = 2,
    parameter int CNTW = 4
) (
    input  logic            fclk,
    input  logic            resetn,
    input  logic            cmatpg,
    input  logic [NPIN-1:0] pad_in,
    input  logic [NPIN-1:0] filt_en,
    input  logic [CNTW-1:0] filt_len,
    input  logic [NPIN-1:0] evt_clr,
    output logic [NPIN-1:0] gpio_in,
    output logic [NPIN-1:0] rise_evt,
    output logic [NPIN-1:0] fall_evt,
    output logic [NPIN-1:0] evt_pend,
    output logic            evt_irq
);

    logic [NPIN-1:0] sync_r [SYNC];
    logic [NPIN-1:0] sync_s;
    logic [NPIN-1:0] gpio_r;
    logic [NPIN-1:0] gpio_nxt_s;
    logic [CNTW-1:0] cnt_r     [NPIN];
    logic [CNTW-1:0] cnt_nxt_s [NPIN];

    // Synchroniser chain; stage 0 samples the raw pads.
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < SYNC; k++) begin
                sync_r[k] <= {NPIN{1'b0}};
            end
        end else begin
            sync_r[0] <= pad_in;
            for (int k = 1; k < SYNC; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC-1];

    // Consecutive-sample filter; >= lets a shortened filt_len release a long-running count at once.
    always_comb begin
        for (int i = 0; i < NPIN; i++) begin
            gpio_nxt_s[i] = gpio_r[i];
            cnt_nxt_s[i]  = {CNTW{1'b0}};
            if (cmatpg || !filt_en[i]) begin
                gpio_nxt_s[i] = sync_s[i];
            end else if (sync_s[i] == gpio_r[i]) begin
                cnt_nxt_s[i] = {CNTW{1'b0}};
            end else if (cnt_r[i] >= filt_len) begin
                gpio_nxt_s[i] = sync_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Filter state and conditioned level registers.
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            gpio_r <= {NPIN{1'b0}};
            for (int i = 0; i < NPIN; i++) begin
                cnt_r[i] <= {CNTW{1'b0}};
            end
        end else begin
            gpio_r <= gpio_nxt_s;
            for (int i = 0; i < NPIN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign gpio_in = gpio_r;

`ifdef BIO_GPIO_EDGE_EN
    logic [NPIN-1:0] gpio_d_r;
    logic [NPIN-1:0] rise_r;
    logic [NPIN-1:0] fall_r;
    logic [NPIN-1:0] pend_r;
    logic            irq_r;

    // Edge pulses one cycle after the level changes; a pending set beats a same-cycle clear.
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            gpio_d_r <= {NPIN{1'b0}};
            rise_r   <= {NPIN{1'b0}};
            fall_r   <= {NPIN{1'b0}};
            pend_r   <= {NPIN{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            gpio_d_r <= gpio_r;
            rise_r   <= gpio_r & ~gpio_d_r;
            fall_r   <= ~gpio_r & gpio_d_r;
            pend_r   <= (pend_r & ~evt_clr) | rise_r | fall_r;
            irq_r    <= |pend_r;
        end
    end

    assign rise_evt = rise_r;
    assign fall_evt = fall_r;
    assign evt_pend = pend_r;
    assign evt_irq  = irq_r;
`else
    logic [NPIN-1:0] pend_r;

    // Nothing can set this flag, so it stays zero; it only gives evt_clr a sink.
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            pend_r <= {NPIN{1'b0}};
        end else begin
            pend_r <= pend_r & ~evt_clr;
        end
    end

    assign rise_evt = {NPIN{1'b0}};
    assign fall_evt = {NPIN{1'b0}};
    assign evt_pend = pend_r;
    assign evt_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_bio_gpio_infilt.sv
// Directed bench for bio_gpio_infilt with a run-length/queue reference model checked every cycle.
module tb_bio_gpio_infilt;
    localparam int NPIN = 32;
    localparam int SYNC = 2;
    localparam int CNTW = 4;
`ifdef BIO_GPIO_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif
    localparam logic [NPIN-1:0] EMASK = {NPIN{EDGE}};
    localparam logic [NPIN-1:0] PAT   = 32'hA5C3_0F69;

    logic            fclk;
    logic            resetn;
    logic            cmatpg;
    logic [NPIN-1:0] pad_in;
    logic [NPIN-1:0] filt_en;
    logic [CNTW-1:0] filt_len;
    logic [NPIN-1:0] evt_clr;
    logic [NPIN-1:0] gpio_in;
    logic [NPIN-1:0] rise_evt;
    logic [NPIN-1:0] fall_evt;
    logic [NPIN-1:0] evt_pend;
    logic            evt_irq;

    bio_gpio_infilt #(.NPIN(NPIN), .SYNC(SYNC), .CNTW(CNTW)) dut (
        .fclk(fclk), .resetn(resetn), .cmatpg(cmatpg), .pad_in(pad_in),
        .filt_en(filt_en), .filt_len(filt_len), .evt_clr(evt_clr),
        .gpio_in(gpio_in), .rise_evt(rise_evt), .fall_evt(fall_evt),
        .evt_pend(evt_pend), .evt_irq(evt_irq)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model: pad history queue models the synchroniser delay, run[] is the mismatch run length.
    logic [NPIN-1:0] padq[$];
    logic [NPIN-1:0] m_gpio, m_prev, m_rise, m_fall, m_pend;
    logic            m_irq;
    int              run [NPIN];

    task automatic chk(input string name, input logic [NPIN-1:0] act, input logic [NPIN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {{(NPIN-1){1'b0}}, act}, {{(NPIN-1){1'b0}}, exp});
    endtask

    task automatic model_reset();
        padq.delete();
        repeat (SYNC) padq.push_back({NPIN{1'b0}});
        m_gpio = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
        for (int i = 0; i < NPIN; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [NPIN-1:0] s, nr, nf, np;
        logic            ni;
        if (!resetn) begin
            model_reset();
        end else begin
            s  = padq[0];
            nr = m_gpio & ~m_prev & EMASK;
            nf = ~m_gpio & m_prev & EMASK;
            np = ((m_pend & ~evt_clr) | m_rise | m_fall) & EMASK;
            ni = (|m_pend) & EDGE;
            m_prev = m_gpio;
            for (int i = 0; i < NPIN; i++) begin
                if (cmatpg || !filt_en[i]) begin
                    m_gpio[i] = s[i];
                    run[i] = 0;
                end else if (s[i] == m_gpio[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] > int'(filt_len)) begin
                        m_gpio[i] = s[i];
                        run[i] = 0;
                    end
                end
            end
            m_rise = nr; m_fall = nf; m_pend = np; m_irq = ni;
            void'(padq.pop_front());
            padq.push_back(pad_in);
        end
    endtask

    task automatic step();
        @(posedge fclk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge fclk) begin
        if (cmp_on) begin
            chk("m_gpio_in", gpio_in, m_gpio);
            chk("m_rise_evt", rise_evt, m_rise);
            chk("m_fall_evt", fall_evt, m_fall);
            chk("m_evt_pend", evt_pend, m_pend);
            chk1("m_evt_irq", evt_irq, m_irq);
        end
    end

    initial begin
        resetn = 1'b0; cmatpg = 1'b0; pad_in = '0; filt_en = '0; filt_len = '0; evt_clr = '0;
        model_reset();
        #2;
        chk("rst_gpio", gpio_in, '0);
        chk("rst_rise", rise_evt, '0);
        chk("rst_pend", evt_pend, '0);
        chk1("rst_irq", evt_irq, 1'b0);
        cmp_on = 1'b1;
        step(); step();
        resetn = 1'b1;
        step();

        // Unfiltered rise on pin 0
        pad_in[0] = 1'b1;
        step(); step();
        chk1("t1_gpio_e2", gpio_in[0], 1'b0);
        step();
        chk1("t1_gpio_e3", gpio_in[0], 1'b1);
        chk1("t1_rise_e3", rise_evt[0], 1'b0);
        step();
        chk1("t1_rise_e4", rise_evt[0], EDGE);
        step();
        chk1("t1_rise_e5", rise_evt[0], 1'b0);
        chk1("t1_pend_e5", evt_pend[0], EDGE);
        chk1("t1_irq_e5", evt_irq, 1'b0);
        step();
        chk1("t1_irq_e6", evt_irq, EDGE);
        evt_clr = '1; step(); evt_clr = '0; step(); step();

        // Filter length 3 on pin 5: 3-cycle glitch rejected, 4-cycle pulse passes
        filt_en[5] = 1'b1; filt_len = 4'd3; step();
        pad_in[5] = 1'b1; repeat (3) step();
        pad_in[5] = 1'b0; repeat (8) step();
        chk1("t2_glitch", gpio_in[5], 1'b0);
        pad_in[5] = 1'b1; repeat (5) step();
        chk1("t2_gpio_e5", gpio_in[5], 1'b0);
        step();
        chk1("t2_gpio_e6", gpio_in[5], 1'b1);

        // filt_len cut from 15 to 2 after 10 mismatched cycles on pin 9
        filt_en[9] = 1'b1; filt_len = 4'd15; step();
        pad_in[9] = 1'b1; repeat (12) step();
        chk1("t3_gpio_hold", gpio_in[9], 1'b0);
        filt_len = 4'd2; step();
        chk1("t3_gpio_flip", gpio_in[9], 1'b1);
        pad_in[9] = 1'b0; repeat (4) step();
        chk1("t3_cnt_restart_e4", gpio_in[9], 1'b1);
        step();
        chk1("t3_cnt_restart_e5", gpio_in[9], 1'b0);

        // Clear colliding with a fall event on pin 7
        pad_in[7] = 1'b1; repeat (6) step();
        evt_clr = '1; step(); evt_clr = '0; step(); step();
        pad_in[7] = 1'b0; repeat (4) step();
        chk1("t4_fall", fall_evt[7], EDGE);
        evt_clr[7] = 1'b1; step();
        chk1("t4_set_wins", evt_pend[7], EDGE);
        step();
        chk1("t4_clr", evt_pend[7], 1'b0);
        evt_clr = '0; step();
        chk1("t4_irq_low", evt_irq, 1'b0);

        // Scan mode bypasses the filter; then the same filter length applies for real
        cmatpg = 1'b1; filt_en = '1; filt_len = 4'd15;
        pad_in = PAT; repeat (3) step();
        chk("t5_bypass_a", gpio_in, PAT);
        pad_in = ~PAT; repeat (3) step();
        chk("t5_bypass_b", gpio_in, ~PAT);
        cmatpg = 1'b0; pad_in = PAT; repeat (17) step();
        chk("t5_filt_e17", gpio_in, ~PAT);
        step();
        chk("t5_filt_e18", gpio_in, PAT);

        // Asynchronous reset mid-count, then pins held high through release
        filt_len = 4'd3; pad_in = '1; repeat (3) step();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        chk("t6_async_gpio", gpio_in, '0);
        chk("t6_async_pend", evt_pend, '0);
        chk1("t6_async_irq", evt_irq, 1'b0);
        step(); step();
        resetn = 1'b1;
        repeat (5) step();
        chk("t6_gpio_e5", gpio_in, '0);
        step();
        chk("t6_gpio_e6", gpio_in, '1);
        chk("t6_rise_e6", rise_evt, '0);
        step();
        chk("t6_rise_e7", rise_evt, EMASK);
        step();
        chk("t6_rise_e8", rise_evt, '0);
        chk("t6_pend_e8", evt_pend, EMASK);
        repeat (3) step();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bio_gpio_infilt.md
Name: bio_gpio_infilt

Overview:
Input conditioning stage directly upstream of the BIO+DMA block's gpio_in bus. It takes raw, asynchronous pad inputs and, per pin:
- synchronises them into the fclk domain;
- optionally rejects glitches with a programmable-length consecutive-sample filter;
- produces clean levels for the BIO core;
- produces rising/falling edge events with sticky pending flags.

Output gpio_in connects 1:1 to the BIO wrapper's gpio_in port.

Parameters:
NPIN, 32, number of GPIO pins conditioned.
SYNC, 2, synchroniser depth in flops (legal range 2..4).
CNTW, 4, filter counter width; max filter length 2^CNTW-1.

Ports:
fclk  input  1  BIO block clock; all state on rising edge.
resetn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally to fclk.
cmatpg  input  1  scan/ATPG mode; forces filter bypass.
pad_in  input  NPIN  raw asynchronous pad inputs.
filt_en  input  NPIN  per-pin filter enable; quasi-static.
filt_len  input  CNTW  global filter length N.
evt_clr  input  NPIN  write-1-to-clear for evt_pend.
gpio_in  output  NPIN  conditioned level to BIO core.
rise_evt  output  NPIN  one-cycle pulse on filtered 0->1.
fall_evt  output  NPIN  one-cycle pulse on filtered 1->0.
evt_pend  output  NPIN  sticky edge-pending flags.
evt_irq  output  1  OR-reduction of evt_pend, registered.

Behaviour:
Reset:
- All synchroniser flops, filter counters, gpio_in, rise_evt, fall_evt, evt_pend and evt_irq are 0.

Synchroniser:
- SYNC-flop chain per pin; s[i] is the last stage.
- No reset-free flops.

Filter, per pin i, evaluated every fclk edge:
- If cmatpg=1 or filt_en[i]=0: gpio_in[i]<=s[i]; cnt[i]<=0.
- Else if s[i]==gpio_in[i]: cnt[i]<=0.
- Else if cnt[i]>=filt_len: gpio_in[i]<=s[i]; cnt[i]<=0.
- Else: cnt[i]<=cnt[i]+1.
- The >= compare handles filt_len reduced mid-count: the pin flips on the next mismatched cycle.
- The counter never wraps; it saturates by construction.
- A mismatch must persist N+1 consecutive fclk cycles to propagate. Any intervening match restarts the count.

Latency, pad edge to gpio_in, counting fclk edges after pad settles before edge 1:
- Filter off: SYNC+1.
- Filter on: SYNC+N+1.
- N=0 with filter on equals filter off.

Filter enable changes:
- Enabling: cnt starts from 0 with gpio_in unchanged.
- Disabling mid-count: gpio_in takes s[i] on the next edge.

Edge detection:
- rise_evt[i]=gpio_in[i] & ~gpio_in_d[i]; fall_evt[i]=~gpio_in[i] & gpio_in_d[i]. gpio_in_d is a one-cycle-delayed copy, reset 0.
- Outputs are registered: each pulse is exactly one cycle, one cycle after gpio_in changes.
- A pin held high through reset release produces one rise_evt after SYNC+1 (filter off) or SYNC+N+1 (filter on) cycles. This is intended, so software sees initial state.

Pending flags:
- evt_pend[i] sets on rise_evt[i]|fall_evt[i]; clears on evt_clr[i].
- Simultaneous set and clear: set wins.
- evt_irq <= |evt_pend, one cycle after evt_pend.

Optional Feature:
BIO_GPIO_EDGE_EN:
- Defined: edge detection, rise_evt, fall_evt, evt_pend and evt_irq operate as above.
- Undefined: gpio_in_d and the pending logic are not instantiated. rise_evt, fall_evt, evt_pend and evt_irq are tied to 0; evt_clr is ignored. Synchroniser and filter are unaffected.

Test Plan:
1. Reset, SYNC=2, filt_en=0, pad_in[0] 0->1 -> gpio_in[0]=1 at edge 3; rise_evt[0] pulses one cycle at edge 4; evt_pend[0]=1; evt_irq=1 one cycle later.
2. filt_en[5]=1, filt_len=3:
   - pad_in[5] high for 3 cycles then low -> gpio_in[5] stays 0, no events.
   - pad_in[5] high for 4 cycles -> gpio_in[5]=1 at edge 6 after pad change.
3. filt_len=15 with filter on, pin mismatched 10 cycles, then filt_len written to 2 -> gpio_in flips on the next edge; cnt returns to 0.
4. Drive pad_in[7] 1->0 so fall_evt[7] and evt_clr[7] are asserted in the same cycle -> evt_pend[7] remains 1. Next cycle evt_clr[7]=1 alone -> evt_pend[7]=0; evt_irq=0 one cycle later if no other pin pending.
5. cmatpg=1 with filt_en=all-ones, filt_len=15 -> every pin's gpio_in follows pad_in with SYNC+1 latency.
6. Assert resetn low mid-filter-count with pins high -> all outputs 0 immediately (asynchronous). After release, pins held high produce rise_evt at SYNC+N+1. Build with BIO_GPIO_EDGE_EN undefined -> event outputs constant 0 throughout.
